huc6280_timer_irq: RTL and testbench

Memory-mapped interval timer and interrupt controller on the CPU bus, in the HuC6280 I/O page next to `cpu_65c02`. It decodes CPU bus cycles (`AB`, `DO`, `WE`) for the timer and interrupt-controller registers. It combines the timer request with two external level requests, applies the disable mask, and drives the `IRQ` input of `cpu_65c02`. Read data is returned registered, with the same one-cycle latency as the bus memory, for the system read mux.

---
 rtl/huc6280_timer_irq_if.sv | 13 +
 rtl/huc6280_timer_irq.sv | 122 ++++++++++++
 tb/tb_huc6280_timer_irq.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/huc6280_timer_irq_if.sv
// CPU-side bus bundle for the HuC6280 timer/interrupt block.
// The master drives address, data and strobes; the slave answers with registered read data.
interface huc6280_timer_irq_if;
    logic        cs;
    logic [15:0] AB;
    logic [7:0]  DO;
    logic        WE;
    logic [7:0]  rdata;
    logic        rdata_valid;

    modport master (output cs, AB, DO, WE, input rdata, rdata_valid);
    modport slave  (input cs, AB, DO, WE, output rdata, rdata_valid);
endinterface

// File: rtl/huc6280_timer_irq.sv
// HuC6280 interval timer plus IRQ controller: TIQ, IRQ1, IRQ2 sources, mask, and the CPU IRQ line.
// Read data is registered with one cycle of latency; the bus has no backpressure and every cycle is accepted.
module huc6280_timer_irq #(
    parameter int PRESCALE = 1024
) (
    input  logic                clk,
    input  logic                reset,
    huc6280_timer_irq_if.slave  bus,
    input  logic                irq1_n,
    input  logic                irq2_n,
    output logic                IRQ,
    output logic [2:0]          irq_src
);
    localparam int PW = $clog2(PRESCALE);
    localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);

    logic [6:0]    reload_q, reload_d;
    logic          en_q, en_d;
    logic [6:0]    counter_q, counter_d;
    logic [PW-1:0] prescaler_q, prescaler_d;
    logic [2:0]    mask_q, mask_d;
    logic          tiq_pend_q, tiq_pend_d;
    logic          irq1_s_q, irq1_s_d;
    logic          irq2_s_q, irq2_s_d;
    logic          irq_q, irq_d;
    logic [7:0]    rdata_q, rdata_d;
    logic          rdata_valid_q, rdata_valid_d;

    logic tmr_win, irq_win, rd;
    logic wr_reload, wr_ctrl, wr_mask, wr_ack;

    // Only AB[12:10] and AB[1:0] decode; the rest of the window aliases.
    logic unused_bits;
    assign unused_bits = ^{bus.AB[15:13], bus.AB[9:2], bus.DO[7]};

    assign tmr_win   = bus.cs && (bus.AB[12:10] == 3'b011);
    assign irq_win   = bus.cs && (bus.AB[12:10] == 3'b101);
    assign rd        = bus.cs && !bus.WE;
    assign wr_reload = tmr_win && bus.WE && !bus.AB[0];
    assign wr_ctrl   = tmr_win && bus.WE &&  bus.AB[0];
    assign wr_mask   = irq_win && bus.WE && (bus.AB[1:0] == 2'd2);
    assign wr_ack    = irq_win && bus.WE && (bus.AB[1:0] == 2'd3);

    assign irq_src   = {tiq_pend_q, irq1_s_q, irq2_s_q} & ~mask_q;

    always_comb begin
        reload_d    = wr_reload ? bus.DO[6:0] : reload_q;
        en_d        = wr_ctrl   ? bus.DO[0]   : en_q;
        mask_d      = wr_mask   ? bus.DO[2:0] : mask_q;
        counter_d   = counter_q;
        prescaler_d = prescaler_q;
        tiq_pend_d  = tiq_pend_q && !wr_ack;

        if (en_q) begin
            if (prescaler_q != '0) begin
                prescaler_d = prescaler_q - 1'b1;
            end else begin
                prescaler_d = PRE_MAX;
                if (counter_q != 7'd0) begin
                    counter_d = counter_q - 7'd1;
                end else begin
                    // Underflow beats a same-cycle ack.
                    counter_d  = reload_q;
                    tiq_pend_d = 1'b1;
                end
            end
        end else if (wr_ctrl && bus.DO[0]) begin
            counter_d   = reload_q;
            prescaler_d = PRE_MAX;
        end

        irq1_s_d = !irq1_n;
        irq2_s_d = !irq2_n;
        irq_d    = |irq_src;

        rdata_d = 8'h00;
        if (rd) begin
            if (tmr_win) begin
                rdata_d = bus.AB[0] ? {7'b0, en_q} : {1'b0, counter_q};
            end else if (irq_win) begin
                case (bus.AB[1:0])
                    2'd2:    rdata_d = {5'b0, mask_q};
                    2'd3:    rdata_d = {5'b0, tiq_pend_q, irq1_s_q, irq2_s_q};
                    default: rdata_d = 8'h00;
                endcase
            end
        end
        rdata_valid_d = rd;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            reload_q      <= 7'd0;
            en_q          <= 1'b0;
            counter_q     <= 7'd0;
            prescaler_q   <= PRE_MAX;
            mask_q        <= 3'd0;
            tiq_pend_q    <= 1'b0;
            irq1_s_q      <= 1'b0;
            irq2_s_q      <= 1'b0;
            irq_q         <= 1'b0;
            rdata_q       <= 8'h00;
            rdata_valid_q <= 1'b0;
        end else begin
            reload_q      <= reload_d;
            en_q          <= en_d;
            counter_q     <= counter_d;
            prescaler_q   <= prescaler_d;
            mask_q        <= mask_d;
            tiq_pend_q    <= tiq_pend_d;
            irq1_s_q      <= irq1_s_d;
            irq2_s_q      <= irq2_s_d;
            irq_q         <= irq_d;
            rdata_q       <= rdata_d;
            rdata_valid_q <= rdata_valid_d;
        end
    end

    assign IRQ             = irq_q;
    assign bus.rdata       = rdata_q;
    assign bus.rdata_valid = rdata_valid_q;
endmodule

// File: tb/tb_huc6280_timer_irq.sv
// Bench for huc6280_timer_irq: directed vector table, timer corner sequences,
// and random bus traffic against a cycle-position model of the timer and IRQ logic.
module tb_huc6280_timer_irq;
    localparam int P = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       irq1_n, irq2_n;
    logic       IRQ;
    logic [2:0] irq_src;

    huc6280_timer_irq_if bus();

    huc6280_timer_irq #(.PRESCALE(P)) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .irq1_n  (irq1_n),
        .irq2_n  (irq2_n),
        .IRQ     (IRQ),
        .irq_src (irq_src)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic        cs, we;
        logic [15:0] ab;
        logic [7:0]  d;
        logic        i1n, i2n;
        logic [7:0]  rd;
        logic        rv, irq;
        logic [2:0]  src;
    } vec_t;

    vec_t vecs[21];

    // Model state: the timer is a position within the current period rather than prescaler/counter.
    logic [6:0] m_reload, m_L;
    int         m_pos;
    logic       m_en, m_tiq, m_i1, m_i2, m_rv, m_irq;
    logic [2:0] m_mask;
    logic [7:0] m_rdata;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic c, input logic we, input logic [15:0] ab, input logic [7:0] d);
        bus.cs = c; bus.WE = we; bus.AB = ab; bus.DO = d;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input logic c, input logic we, input logic [15:0] ab, input logic [7:0] d);
        drive(c, we, ab, d);
        tick();
    endtask

    task automatic do_reset;
        reset = 1'b1;
        drive(1'b0, 1'b0, 16'h0000, 8'h00);
        tick(); tick();
        reset = 1'b0;
    endtask

    task automatic mstep(input logic rst, input logic c, input logic we, input logic [15:0] ab,
                         input logic [7:0] d, input logic p1n, input logic p2n);
        int         cnt;
        logic       tw, iw, ufl;
        logic [7:0] rv;
        if (rst) begin
            m_reload = 7'd0; m_en = 1'b0; m_L = 7'd0; m_pos = 0; m_mask = 3'd0;
            m_tiq = 1'b0; m_i1 = 1'b0; m_i2 = 1'b0; m_rdata = 8'h00; m_rv = 1'b0; m_irq = 1'b0;
            return;
        end
        cnt = int'(m_L) - m_pos / P;
        tw  = c && (ab[12:10] == 3'b011);
        iw  = c && (ab[12:10] == 3'b101);
        rv  = 8'h00;
        if (tw)                          rv = ab[0] ? {7'b0, m_en} : 8'(cnt);
        else if (iw && ab[1:0] == 2'd2)  rv = {5'b0, m_mask};
        else if (iw && ab[1:0] == 2'd3)  rv = {5'b0, m_tiq, m_i1, m_i2};
        m_rv    = c && !we;
        m_rdata = m_rv ? rv : 8'h00;
        m_irq   = |({m_tiq, m_i1, m_i2} & ~m_mask);
        ufl = 1'b0;
        if (m_en) begin
            if (m_pos == (int'(m_L) + 1) * P - 1) begin
                m_L = m_reload; m_pos = 0; ufl = 1'b1;
            end else begin
                m_pos++;
            end
        end else if (tw && we && ab[0] && d[0]) begin
            m_L = m_reload; m_pos = 0;
        end
        if (ufl)                              m_tiq = 1'b1;
        else if (iw && we && ab[1:0] == 2'd3) m_tiq = 1'b0;
        if (tw && we && !ab[0])               m_reload = d[6:0];
        if (tw && we && ab[0])                m_en = d[0];
        if (iw && we && ab[1:0] == 2'd2)      m_mask = d[2:0];
        m_i1 = !p1n;
        m_i2 = !p2n;
    endtask

    initial begin
        logic        exp_tiq, exp_s2, prev_s2, r_rst, c, we, p1n, p2n;
        logic [15:0] ab;
        logic [7:0]  d;

        vecs[0]  = '{1'b1, 1'b0, 16'h0C00, 8'h00, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 3'b000};
        vecs[1]  = '{1'b1, 1'b0, 16'h0C01, 8'h00, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 3'b000};
        vecs[2]  = '{1'b1, 1'b0, 16'h1402, 8'h00, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 3'b000};
        vecs[3]  = '{1'b1, 1'b0, 16'h1403, 8'h00, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 3'b000};
        vecs[4]  = '{1'b1, 1'b1, 16'h1402, 8'h05, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 3'b000};
        vecs[5]  = '{1'b1, 1'b0, 16'h1402, 8'h00, 1'b1, 1'b1, 8'h05, 1'b1, 1'b0, 3'b000};
        vecs[6]  = '{1'b1, 1'b1, 16'h0C00, 8'hFF, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 3'b000};
        vecs[7]  = '{1'b1, 1'b0, 16'h0C00, 8'h00, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 3'b000};
        vecs[8]  = '{1'b0, 1'b0, 16'h0C00, 8'h00, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 3'b000};
        vecs[9]  = '{1'b1, 1'b0, 16'h1400, 8'h00, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 3'b000};
        vecs[10] = '{1'b1, 1'b0, 16'h1403, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 3'b010};
        vecs[11] = '{1'b1, 1'b0, 16'h1403, 8'h00, 1'b0, 1'b1, 8'h02, 1'b1, 1'b1, 3'b010};
        vecs[12] = '{1'b1, 1'b1, 16'h1402, 8'h02, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 3'b001};
        vecs[13] = '{1'b1, 1'b0, 16'h1403, 8'h00, 1'b0, 1'b0, 8'h03, 1'b1, 1'b1, 3'b001};
        vecs[14] = '{1'b1, 1'b0, 16'h1402, 8'h00, 1'b1, 1'b1, 8'h02, 1'b1, 1'b1, 3'b000};
        vecs[15] = '{1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 3'b000};
        vecs[16] = '{1'b1, 1'b1, 16'h0C00, 8'h03, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 3'b000};
        vecs[17] = '{1'b1, 1'b0, 16'h0C00, 8'h00, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 3'b000};
        vecs[18] = '{1'b1, 1'b0, 16'h17FE, 8'h00, 1'b1, 1'b1, 8'h02, 1'b1, 1'b0, 3'b000};
        vecs[19] = '{1'b1, 1'b0, 16'h0800, 8'h00, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 3'b000};
        vecs[20] = '{1'b1, 1'b0, 16'h0FFD, 8'h00, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 3'b000};

        irq1_n = 1'b1; irq2_n = 1'b1;
        do_reset();
        chk("reset_irq",   16'(IRQ), 16'h0);
        chk("reset_src",   16'(irq_src), 16'h0);
        chk("reset_rv",    16'(bus.rdata_valid), 16'h0);
        chk("reset_rdata", 16'(bus.rdata), 16'h0);

        for (int i = 0; i < 21; i++) begin
            irq1_n = vecs[i].i1n; irq2_n = vecs[i].i2n;
            cyc(vecs[i].cs, vecs[i].we, vecs[i].ab, vecs[i].d);
            chk($sformatf("vec%0d_rv", i),  16'(bus.rdata_valid), 16'(vecs[i].rv));
            chk($sformatf("vec%0d_irq", i), 16'(IRQ), 16'(vecs[i].irq));
            chk($sformatf("vec%0d_src", i), 16'(irq_src), 16'(vecs[i].src));
            if (vecs[i].rv) chk($sformatf("vec%0d_rdata", i), 16'(bus.rdata), 16'(vecs[i].rd));
        end

        // Countdown, ack, mask, and ack colliding with underflow; reload 2 gives a 12-cycle period.
        irq1_n = 1'b1; irq2_n = 1'b1;
        do_reset();
        cyc(1'b1, 1'b1, 16'h0C00, 8'h02);
        cyc(1'b1, 1'b1, 16'h0C01, 8'h01);
        prev_s2 = 1'b0;
        for (int t = 1; t <= 52; t++) begin
            case (t)
                14:      drive(1'b1, 1'b0, 16'h0C00, 8'h00);
                15, 31:  drive(1'b1, 1'b1, 16'h1403, 8'h5A);
                32:      drive(1'b1, 1'b1, 16'h1402, 8'h04);
                38:      drive(1'b1, 1'b0, 16'h1403, 8'h00);
                40:      drive(1'b1, 1'b1, 16'h1402, 8'h00);
                48:      drive(1'b1, 1'b1, 16'h1403, 8'hFF);
                default: drive(1'b0, 1'b0, 16'h0000, 8'h00);
            endcase
            tick();
            exp_tiq = (t >= 12 && t < 15) || (t >= 24 && t < 31) || (t >= 36);
            exp_s2  = exp_tiq && !(t >= 32 && t < 40);
            chk($sformatf("tmr_src_t%0d", t), 16'(irq_src), 16'({exp_s2, 2'b00}));
            chk($sformatf("tmr_irq_t%0d", t), 16'(IRQ), 16'(prev_s2));
            prev_s2 = exp_s2;
            if (t == 14) chk("tmr_counter_after_reload", 16'(bus.rdata), 16'h02);
            if (t == 38) chk("tmr_status_masked", 16'(bus.rdata), 16'h04);
        end

        // Stop with counter at 5, restart from reload, then reset mid-run alongside a bus write.
        do_reset();
        cyc(1'b1, 1'b1, 16'h0C00, 8'h07);
        cyc(1'b1, 1'b1, 16'h0C01, 8'h01);
        repeat (8) cyc(1'b0, 1'b0, 16'h0000, 8'h00);
        cyc(1'b1, 1'b1, 16'h0C01, 8'h00);
        cyc(1'b1, 1'b0, 16'h0C00, 8'h00);
        chk("stop_counter_first", 16'(bus.rdata), 16'h05);
        repeat (19) cyc(1'b0, 1'b0, 16'h0000, 8'h00);
        cyc(1'b1, 1'b0, 16'h0C00, 8'h00);
        chk("stop_counter_held", 16'(bus.rdata), 16'h05);
        cyc(1'b1, 1'b1, 16'h0C00, 8'h03);
        cyc(1'b1, 1'b1, 16'h0C01, 8'h01);
        cyc(1'b1, 1'b0, 16'h0C00, 8'h00);
        chk("restart_counter", 16'(bus.rdata), 16'h03);
        cyc(1'b1, 1'b0, 16'h0C01, 8'h00);
        chk("restart_en", 16'(bus.rdata), 16'h01);
        repeat (16) cyc(1'b0, 1'b0, 16'h0000, 8'h00);
        chk("restart_irq", 16'(IRQ), 16'h1);
        chk("restart_src", 16'(irq_src), 16'h4);
        reset = 1'b1;
        cyc(1'b1, 1'b1, 16'h0C01, 8'h01);
        reset = 1'b0;
        chk("midrst_irq",   16'(IRQ), 16'h0);
        chk("midrst_src",   16'(irq_src), 16'h0);
        chk("midrst_rv",    16'(bus.rdata_valid), 16'h0);
        chk("midrst_rdata", 16'(bus.rdata), 16'h0);
        cyc(1'b1, 1'b0, 16'h0C01, 8'h00);
        chk("midrst_en", 16'(bus.rdata), 16'h00);
        cyc(1'b1, 1'b0, 16'h1402, 8'h00);
        chk("midrst_mask", 16'(bus.rdata), 16'h00);
        repeat (20) cyc(1'b0, 1'b0, 16'h0000, 8'h00);
        cyc(1'b1, 1'b0, 16'h0C00, 8'h00);
        chk("midrst_counter_stopped", 16'(bus.rdata), 16'h00);
        chk("midrst_src_idle", 16'(irq_src), 16'h0);

        // Random bus traffic against the model.
        p1n = 1'b1; p2n = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            r_rst = (i == 0) || ($urandom_range(0, 299) == 0);
            c  = ($urandom_range(0, 7) != 0);
            we = ($urandom_range(0, 3) == 0);
            d  = 8'($urandom_range(0, 255));
            case ($urandom_range(0, 8))
                0:       begin ab = 16'h0C00; d = d & 8'h87; end
                1:       begin ab = 16'h0C01; d[0] = ($urandom_range(0, 3) != 0); end
                2:       ab = 16'h1402;
                3:       ab = 16'h1403;
                4:       ab = 16'h1400 | 16'($urandom_range(0, 1));
                5:       ab = 16'($urandom_range(0, 65535));
                6:       begin ab = 16'h0FFD; d[0] = 1'b1; end
                7:       ab = 16'h17FF;
                default: ab = 16'h0C02;
            endcase
            if ($urandom_range(0, 15) == 0) p1n = ~p1n;
            if ($urandom_range(0, 15) == 0) p2n = ~p2n;
            reset = r_rst; irq1_n = p1n; irq2_n = p2n;
            cyc(c, we, ab, d);
            mstep(r_rst, c, we, ab, d, p1n, p2n);
            chk("rnd_irq", 16'(IRQ), 16'(m_irq));
            chk("rnd_src", 16'(irq_src), 16'({m_tiq, m_i1, m_i2} & ~m_mask));
            chk("rnd_rv",  16'(bus.rdata_valid), 16'(m_rv));
            if (m_rv) chk("rnd_rdata", 16'(bus.rdata), 16'(m_rdata));
        end
        reset = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
